// File: rtl/ecc_pkg.sv
// ----------------------------------------------------------------------------
// ecc_pkg
// Shared constants for the ECC point datapath: scalar and point widths,
// ALU opcodes, the encoding of the point at infinity, and the state
// encoding of the scalar-multiplication sequencer.
// A point is {inf, x[63:0], y[63:0]}; the MSB flags the point at infinity.
// ----------------------------------------------------------------------------
package ecc_pkg;

    localparam int ECC_KW      = 64;
    localparam int ECC_PW      = 129;
    localparam int ECC_INF_BIT = 128;

    localparam logic [1:0] ECC_OP_ADD = 2'd0;
    localparam logic [1:0] ECC_OP_SUB = 2'd1;
    localparam logic [1:0] ECC_OP_DBL = 2'd2;

    localparam logic [ECC_PW-1:0] ECC_PT_INF = {1'b1, {(ECC_PW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BIT      = 3'd1,
        ST_DBL_REQ  = 3'd2,
        ST_DBL_WAIT = 3'd3,
        ST_ADD_REQ  = 3'd4,
        ST_ADD_WAIT = 3'd5,
        ST_FIN      = 3'd6
    } state_e;

endpackage

// File: rtl/ecc_scalar_mul_ctrl.sv
// ----------------------------------------------------------------------------
// ecc_scalar_mul_ctrl
// Computes R = k*P with left-to-right double-and-add by sequencing a shared
// ECC point ALU. The point at infinity is handled locally (bypass), so the
// ALU never sees an infinity operand. An ALU that fails to answer within
// ALU_TIMEOUT cycles aborts the run with err, returning the point at infinity.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               1-cycle request, honoured only in IDLE
//   k, base_pt          scalar and base point, latched on an accepted start
//   busy                high from the cycle after accept until the run ends
//   done, err           1-cycle completion pulse; err marks an ALU timeout
//   result              k*P, held until the next accepted start
//   alu_en              1-cycle ALU start pulse
//   alu_P, alu_Q, alu_op ALU operands/opcode, stable until alu_done
//   alu_R, alu_done     ALU result and completion pulse
// ----------------------------------------------------------------------------
module ecc_scalar_mul_ctrl
    import ecc_pkg::*;
#(
    parameter int         KW          = ECC_KW,
    parameter int         PW          = ECC_PW,
    parameter logic [1:0] OP_ADD      = ECC_OP_ADD,
    parameter logic [1:0] OP_DBL      = ECC_OP_DBL,
    parameter int         ALU_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [PW-1:0] base_pt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] result,
    output logic          alu_en,
    output logic [PW-1:0] alu_P,
    output logic [PW-1:0] alu_Q,
    output logic [1:0]    alu_op,
    input  logic [PW-1:0] alu_R,
    input  logic          alu_done
);

    localparam int IW  = $clog2(KW);
    localparam int CW  = $clog2(ALU_TIMEOUT + 1);
    localparam int INF = PW - 1;

    localparam logic [PW-1:0] PT_INF   = {1'b1, {(PW-1){1'b0}}};
    localparam logic [IW-1:0] IDX_TOP  = IW'(KW - 1);
    // cnt_q holds the number of wait cycles already spent after the issue
    // cycle. Deciding at ALU_TIMEOUT-2 makes the registered done/err appear
    // exactly ALU_TIMEOUT cycles after the alu_en pulse.
    localparam logic [CW-1:0] TMO_LAST = CW'(ALU_TIMEOUT - 2);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] r_q, r_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [PW-1:0] result_q, result_d;
    logic          step;
    logic          timeout;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            p_q      <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            p_q      <= p_d;
            r_q      <= r_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        p_d      = p_q;
        r_d      = r_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        step     = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d     = k;
                    p_d     = base_pt;
                    r_d     = PT_INF;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = ST_BIT;
                end
            end

            ST_BIT: begin
                // While R is still infinity, doubling is a no-op and adding P
                // is just a copy, so the ALU is skipped entirely.
                if (r_q[INF]) begin
                    if (k_q[idx_q]) begin
                        r_d = p_q;
                    end
                    step = 1'b1;
                end else begin
                    state_d = ST_DBL_REQ;
                end
            end

            ST_DBL_REQ: begin
                cnt_d   = '0;
                state_d = ST_DBL_WAIT;
            end

            ST_DBL_WAIT: begin
                if (alu_done) begin
                    r_d = alu_R;
                    if (k_q[idx_q]) begin
                        state_d = ST_ADD_REQ;
                    end else begin
                        step = 1'b1;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_ADD_REQ: begin
                // The doubling may have produced infinity (order-2 point);
                // infinity + P is P without involving the ALU.
                if (r_q[INF]) begin
                    r_d  = p_q;
                    step = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_ADD_WAIT;
                end
            end

            ST_ADD_WAIT: begin
                if (alu_done) begin
                    r_d  = alu_R;
                    step = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Advance to the next scalar bit, or finish after bit 0. The result
        // is captured together with done so both are valid in the FIN cycle.
        if (step) begin
            if (idx_q == '0) begin
                result_d = r_d;
                done_d   = 1'b1;
                state_d  = ST_FIN;
            end else begin
                idx_d   = idx_q - IW'(1);
                state_d = ST_BIT;
            end
        end

        if (timeout) begin
            result_d = PT_INF;
            done_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = ST_FIN;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        alu_en = 1'b0;
        alu_P  = '0;
        alu_Q  = '0;
        alu_op = 2'd0;

        case (state_q)
            ST_DBL_REQ, ST_DBL_WAIT: begin
                alu_en = (state_q == ST_DBL_REQ);
                alu_P  = r_q;
                alu_Q  = r_q;
                alu_op = OP_DBL;
            end
            ST_ADD_REQ, ST_ADD_WAIT: begin
                alu_en = (state_q == ST_ADD_REQ) && !r_q[INF];
                alu_P  = r_q;
                alu_Q  = p_q;
                alu_op = OP_ADD;
            end
            default: begin
                alu_en = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
module tb_ecc_scalar_mul_ctrl;

    localparam int KW  = 64;
    localparam int PW  = 129;
    localparam int TMO = 1024;
    localparam int LAT = 5;
    localparam int BUDGET = 8000;

    localparam logic [PW-1:0] INF_PT = {1'b1, {(PW-1){1'b0}}};
    localparam logic [PW-1:0] P0     = {1'b0, 64'd93, 64'd9};

    typedef logic [2*PW+1:0] oprec_t;   // {op, P, Q}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k = '0;
    logic [PW-1:0] base_pt = '0;
    logic          busy, done, err, alu_en;
    logic [PW-1:0] result, alu_P, alu_Q;
    logic [1:0]    alu_op;
    logic [PW-1:0] alu_R = '0;
    logic          alu_done = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    oprec_t rec_q[$];
    oprec_t exp_ops[$];
    bit     stub_on = 1'b1;
    int     cd = 0;
    logic [PW-1:0] pend = '0;

    int lat, en_at;
    bit busy_ok;

    always #5 clk = ~clk;

    ecc_scalar_mul_ctrl #(.ALU_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k(k), .base_pt(base_pt),
        .busy(busy), .done(done), .err(err), .result(result),
        .alu_en(alu_en), .alu_P(alu_P), .alu_Q(alu_Q), .alu_op(alu_op),
        .alu_R(alu_R), .alu_done(alu_done)
    );

    // Arbitrary but deterministic stand-in for the point ALU; occasionally
    // returns infinity so the bypass paths get exercised.
    function automatic logic [PW-1:0] alu_f(input logic [1:0] op, input logic [PW-1:0] a,
                                            input logic [PW-1:0] b);
        logic [63:0] x, y;
        x = a[127:64] * 64'd5 + b[127:64] * 64'd3 + {62'd0, op};
        y = (a[63:0] + b[63:0]) ^ {x[31:0], x[63:32]};
        return {(x[5:0] == 6'd0), x, y};
    endfunction

    // Stub ALU: records each request, answers a fixed number of cycles later.
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1 && stub_on) begin
                alu_done <= 1'b1;
                alu_R    <= pend;
            end
        end
        if (alu_en) begin
            rec_q.push_back({alu_op, alu_P, alu_Q});
            pend <= alu_f(alu_op, alu_P, alu_Q);
            cd   <= LAT;
        end
    end

    task automatic check_eq(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: double-and-add over the scalar bits, MSB first, treating
    // infinity as the additive identity.
    task automatic model(input logic [KW-1:0] kk, input logic [PW-1:0] p,
                         output logic [PW-1:0] r);
        r = INF_PT;
        exp_ops.delete();
        for (int i = KW - 1; i >= 0; i--) begin
            if (r[PW-1]) begin
                if (kk[i]) r = p;
            end else begin
                exp_ops.push_back({2'd2, r, r});
                r = alu_f(2'd2, r, r);
                if (kk[i]) begin
                    if (r[PW-1]) begin
                        r = p;
                    end else begin
                        exp_ops.push_back({2'd0, r, p});
                        r = alu_f(2'd0, r, p);
                    end
                end
            end
        end
    endtask

    // Issue one start and wait (bounded) for done. lat counts cycles from the
    // start cycle; en_at is the first cycle alu_en was seen high.
    task automatic run(input logic [KW-1:0] kk, input logic [PW-1:0] p, input bit mid_start);
        @(negedge clk);
        rec_q.delete();
        k = kk; base_pt = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; en_at = -1; busy_ok = 1'b1;
        while (!done && lat < BUDGET) begin
            if (!busy) busy_ok = 1'b0;
            if (alu_en && en_at < 0) en_at = lat;
            start = mid_start && (lat == 10);
            if (start) k = 64'd7;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_eq("done_seen", {263'd0, done}, 264'd1);
    endtask

    task automatic check_ops(input string tag);
        check_eq({tag, "_nops"}, 264'(rec_q.size()), 264'(exp_ops.size()));
        for (int i = 0; i < rec_q.size() && i < exp_ops.size(); i++)
            check_eq({tag, "_op"}, 264'(rec_q[i]), 264'(exp_ops[i]));
    endtask

    initial begin
        logic [PW-1:0] er;
        logic [KW-1:0] rk;
        logic [PW-1:0] rp;
        int w;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_ctrl", {258'd0, busy, done, err, alu_en, alu_op}, 264'd0);
        check_eq("rst_result", 264'(result), 264'd0);
        check_eq("rst_aluP", 264'(alu_P), 264'd0);
        check_eq("rst_aluQ", 264'(alu_Q), 264'd0);
        rst_n = 1'b1;

        // k = 0: pure BIT walk, no ALU traffic
        run(64'd0, P0, 1'b0);
        check_eq("k0_lat", 264'(lat), 264'(KW + 1));
        check_eq("k0_result", 264'(result), 264'(INF_PT));
        check_eq("k0_nops", 264'(rec_q.size()), 264'd0);
        check_eq("k0_err", {263'd0, err}, 264'd0);

        // Start on the done cycle must be ignored
        start = 1'b1; k = 64'd1;
        @(negedge clk);
        start = 1'b0;
        check_eq("fin_start_ign", {263'd0, busy}, 264'd0);
        @(negedge clk);
        check_eq("fin_start_ign2", {263'd0, busy}, 264'd0);

        // k = 1: result is P via bypass
        run(64'd1, P0, 1'b0);
        check_eq("k1_result", 264'(result), 264'(P0));
        check_eq("k1_nops", 264'(rec_q.size()), 264'd0);
        check_eq("k1_err", {263'd0, err}, 264'd0);
        check_eq("k1_lat", 264'(lat), 264'(KW + 1));

        // k = 5: DBL(P,P), DBL(R,R), ADD(R,P)
        model(64'd5, P0, er);
        run(64'd5, P0, 1'b0);
        check_eq("k5_model_ops", 264'(exp_ops.size()), 264'd3);
        check_ops("k5");
        check_eq("k5_result", 264'(result), 264'(er));
        check_eq("k5_err", {263'd0, err}, 264'd0);

        // ALU never answers: timeout
        stub_on = 1'b0;
        run(64'd2, P0, 1'b0);
        check_eq("tmo_err", {263'd0, err}, 264'd1);
        check_eq("tmo_result", 264'(result), 264'(INF_PT));
        check_eq("tmo_delay", 264'(lat - en_at), 264'(TMO));
        check_eq("tmo_nops", 264'(rec_q.size()), 264'd1);
        stub_on = 1'b1;
        repeat (8) @(negedge clk);

        // Next start after timeout is accepted normally
        model(64'd6, P0, er);
        run(64'd6, P0, 1'b0);
        check_ops("after_tmo");
        check_eq("after_tmo_result", 264'(result), 264'(er));
        check_eq("after_tmo_err", {263'd0, err}, 264'd0);

        // Second start mid-run is ignored
        model(64'd3, P0, er);
        run(64'd3, P0, 1'b1);
        check_ops("mid");
        check_eq("mid_result", 264'(result), 264'(er));
        check_eq("mid_busy", {263'd0, busy_ok}, 264'd1);

        // Randomized scalars and base points
        for (int t = 0; t < 8; t++) begin
            rk = (t < 4) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(1, 4095));
            rp = {1'b0, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            model(rk, rp, er);
            run(rk, rp, 1'b0);
            check_ops("rnd");
            check_eq("rnd_result", 264'(result), 264'(er));
            check_eq("rnd_busy", {263'd0, busy_ok}, 264'd1);
        end

        // Reset dropped during DBL_WAIT
        @(negedge clk);
        rec_q.delete();
        k = 64'd3; base_pt = P0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!alu_en && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("rst_en_seen", {263'd0, alu_en}, 264'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_ctrl", {258'd0, busy, done, err, alu_en, alu_op}, 264'd0);
        check_eq("arst_result", 264'(result), 264'd0);
        check_eq("arst_aluP", 264'(alu_P), 264'd0);
        check_eq("arst_aluQ", 264'(alu_Q), 264'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("late_done_busy", {263'd0, busy}, 264'd0);
        check_eq("late_done_done", {263'd0, done}, 264'd0);
        check_eq("late_done_nops", 264'(rec_q.size()), 264'd1);

        // Fresh k = 2 after reset: a single doubling
        model(64'd2, P0, er);
        run(64'd2, P0, 1'b0);
        check_eq("post_rst_model", 264'(exp_ops.size()), 264'd1);
        check_ops("post_rst");
        check_eq("post_rst_result", 264'(result), 264'(er));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
